// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end for a pipelined core. It issues word requests
// to an instruction memory with a valid/grant handshake and tracks up to two
// requests in flight. Responses come back in request order, and each one is
// placed in a two-entry instruction buffer. The head of that buffer is shown
// to the fetch/decode pipeline register.
//
// A redirect (taken branch or jump) does three things in one edge:
//   - reloads the fetch PC,
//   - flushes the buffer,
//   - marks every in-flight request as discard.
// A discarded response still pops its outstanding slot, so the memory and
// this block stay in step, but its data never reaches the buffer.
//
// Parameters:
//   RESET_PC     first fetch address after reset
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   StallF       decode is holding; the head instruction is not consumed
//   PCSrcE       redirect request; PCTargetE is the new fetch address
//   PCTargetE    redirect target
//   imem_req     request valid (imem_addr is the fetch PC)
//   imem_addr    request address
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  response valid
//   imem_rdata   response instruction word
//   InstrF       head instruction, or NOP when the buffer is empty
//   PCF          PC of InstrF, or 0 when the buffer is empty
//   ValidF       InstrF/PCF hold a real fetched instruction
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic        ValidF
);

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Fetch PC: the address of the next request.
    logic [31:0]       pc_q, pc_d;

    // Outstanding-address FIFO. Entry 0 is the oldest request.
    logic [1:0][31:0]  opc_q, opc_d;
    logic [1:0]        odisc_q, odisc_d;
    logic [1:0]        ocnt_q, ocnt_d;

    // Instruction buffer. Entry 0 is the head.
    logic [1:0][31:0]  bpc_q, bpc_d;
    logic [1:0][31:0]  binstr_q, binstr_d;
    logic [1:0]        bcnt_q, bcnt_d;

    logic [1:0]        live_cnt;
    logic [2:0]        occupancy;
    logic              accept;
    logic              resp;
    logic              resp_keep;
    logic              valid_f;
    logic              pop_head;

    // Count the in-flight requests whose data will land in the buffer.
    // Discarded slots do not count here.
    always_comb begin
        live_cnt = {1'b0, (ocnt_q != 2'd0) && !odisc_q[0]}
                 + {1'b0, (ocnt_q == 2'd2) && !odisc_q[1]};
    end

    // Issue control.
    // Live requests plus buffered words must leave room in the buffer.
    // Discarded requests still hold FIFO slots until their responses drain.
    // Once raised, the request can only drop on a redirect, because neither
    // a response nor a head pop can raise the occupancy.
    always_comb begin
        occupancy = {1'b0, live_cnt} + {1'b0, bcnt_q};
        imem_req  = rst_n && !PCSrcE && (occupancy < 3'd2) && (ocnt_q < 2'd2);
        imem_addr = pc_q;
        accept    = imem_req && imem_gnt;
        resp      = imem_rvalid && (ocnt_q != 2'd0);
        resp_keep = resp && !odisc_q[0] && !PCSrcE;
        valid_f   = (bcnt_q != 2'd0);
        pop_head  = valid_f && !StallF && !PCSrcE;
    end

    // Head of the buffer is presented combinationally. This lets a word that
    // was written at an edge be visible right after that edge.
    always_comb begin
        ValidF = valid_f;
        InstrF = valid_f ? binstr_q[0] : NOP_INSTR;
        PCF    = valid_f ? bpc_q[0] : 32'h00000000;
    end

    // Fetch PC. A redirect wins over a grant; no grant is possible in a
    // redirect cycle anyway, since imem_req is low then.
    always_comb begin
        pc_d = pc_q;
        if (PCSrcE) begin
            pc_d = PCTargetE;
        end else if (accept) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Outstanding FIFO.
    // The pop happens first, so a push in the same cycle lands behind the
    // surviving entry. Any response pops a slot, even one dropped by a
    // redirect, so the FIFO stays aligned with the memory.
    always_comb begin
        opc_d   = opc_q;
        odisc_d = odisc_q;
        ocnt_d  = ocnt_q;
        if (resp) begin
            opc_d[0]   = opc_q[1];
            odisc_d[0] = odisc_q[1];
            ocnt_d     = ocnt_q - 2'd1;
        end
        if (PCSrcE) begin
            odisc_d = 2'b11;
        end
        if (accept) begin
            opc_d[ocnt_d[0]]   = pc_q;
            odisc_d[ocnt_d[0]] = 1'b0;
            ocnt_d             = ocnt_d + 2'd1;
        end
    end

    // Instruction buffer.
    // The pop happens first, so a write and a pop in the same cycle leave
    // the occupancy unchanged. The issue rule prevents a live response from
    // arriving when the buffer is full; the bcnt_d check only keeps the
    // write index in range.
    always_comb begin
        bpc_d    = bpc_q;
        binstr_d = binstr_q;
        bcnt_d   = bcnt_q;
        if (pop_head) begin
            bpc_d[0]    = bpc_q[1];
            binstr_d[0] = binstr_q[1];
            bcnt_d      = bcnt_q - 2'd1;
        end
        if (resp_keep && (bcnt_d != 2'd2)) begin
            bpc_d[bcnt_d[0]]    = opc_q[0];
            binstr_d[bcnt_d[0]] = imem_rdata;
            bcnt_d              = bcnt_d + 2'd1;
        end
        if (PCSrcE) begin
            bcnt_d = 2'd0;
        end
    end

    // State registers.
    // Reset empties both queues at once. Any response that arrives later
    // finds no outstanding slot and is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            opc_q    <= '0;
            odisc_q  <= '0;
            ocnt_q   <= 2'd0;
            bpc_q    <= '0;
            binstr_q <= '0;
            bcnt_q   <= 2'd0;
        end else begin
            pc_q     <= pc_d;
            opc_q    <= opc_d;
            odisc_q  <= odisc_d;
            ocnt_q   <= ocnt_d;
            bpc_q    <= bpc_d;
            binstr_q <= binstr_d;
            bcnt_q   <= bcnt_d;
        end
    end

endmodule
